// File: rtl/exc_pkg.sv
// Shared definitions for the LEGv8 exception responder: syndrome codes,
// responder state encoding and the default exception vector.
package exc_pkg;

   // Exception syndrome codes reported through ESR
   localparam logic [3:0] ESR_INVALID  = 4'b0001;
   localparam logic [3:0] ESR_IRQ      = 4'b0010;
   localparam logic [3:0] ESR_INCON_BR = 4'b0011;
   localparam logic [3:0] ESR_BAD_ERET = 4'b0100;

   // Default exception vector address
   localparam logic [63:0] EVEC_DEFAULT = 64'h0000_0000_0000_00D8;

   typedef enum logic [1:0] {
      RUN,
      HANDLER,
      HALTED
   } exc_state_t;

endpackage

// File: rtl/exc_sysregs.sv
// ELR/ESR system register storage with a synchronous write port and the
// combinational MRS read mux (00 ELR, 01 ESR, 10 InHandler, 11 zero).
module exc_sysregs #(
   parameter int unsigned N = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         we,
   input  logic [N-1:0] elr_wdata,
   input  logic [3:0]   esr_wdata,
   input  logic [1:0]   sel,
   input  logic         in_handler,
   output logic [N-1:0] elr,
   output logic [3:0]   esr,
   output logic [N-1:0] rdata
);

   logic [N-1:0] elr_q, elr_d;
   logic [3:0]   esr_q, esr_d;

   // Next-value logic for the link and syndrome registers
   always_comb begin
      elr_d = elr_q;
      esr_d = esr_q;
      if (we) begin
         elr_d = elr_wdata;
         esr_d = esr_wdata;
      end
   end

   // Register update with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         elr_q <= '0;
         esr_q <= '0;
      end else begin
         elr_q <= elr_d;
         esr_q <= esr_d;
      end
   end

   // MRS read mux, reflects register values before the current edge
   always_comb begin
      rdata = '0;
      case (sel)
         2'b00:   rdata = elr_q;
         2'b01:   rdata = {{(N-4){1'b0}}, esr_q};
         2'b10:   rdata = {{(N-1){1'b0}}, in_handler};
         default: rdata = '0;
      endcase
   end

   assign elr = elr_q;
   assign esr = esr_q;

endmodule

// File: rtl/exc_unit.sv
// Exception responder for the LEGv8 single-cycle core: cause priority
// encoder, RUN/HANDLER/HALTED state machine and interrupt acknowledge
// handshake. Define EXC_IRQ_EN to enable the external interrupt path;
// without it ExtIRQ is ignored and ExtIAck stays 0.
module exc_unit
   import exc_pkg::*;
#(
   parameter int unsigned     N    = 64,
   parameter logic [N-1:0]    EVEC = EVEC_DEFAULT[N-1:0]
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] PC,
   input  logic         NotAnInstr,
   input  logic         InconBranch,
   input  logic         ERet,
   input  logic         ExtIRQ,
   input  logic [1:0]   SysRegSel,
   output logic         Exc,
   output logic         Kill,
   output logic [N-1:0] EVAddr,
   output logic [N-1:0] RetAddr,
   output logic         RetTake,
   output logic [N-1:0] ELR,
   output logic [3:0]   ESR,
   output logic         InHandler,
   output logic         Halt,
   output logic         ExtIAck,
   output logic [N-1:0] SysRegData
);

`ifdef EXC_IRQ_EN
   localparam bit IrqEn = 1'b1;
`else
   localparam bit IrqEn = 1'b0;
`endif

   exc_state_t state_q, state_d;
   logic       ack_q, ack_d;
   logic       irq_req;
   logic       take;
   logic       exc_c, kill_c, ret_c;
   logic [3:0] esr_w;

   assign irq_req = IrqEn & ExtIRQ;

   // Priority encoder, next-state and redirect/kill decisions
   always_comb begin
      state_d = state_q;
      ack_d   = ack_q;
      take    = 1'b0;
      exc_c   = 1'b0;
      kill_c  = 1'b0;
      ret_c   = 1'b0;
      esr_w   = '0;
      // Handshake release on the first edge with ExtIRQ low; frozen in HALTED
      if (!ExtIRQ && state_q != HALTED) ack_d = 1'b0;
      case (state_q)
         RUN: begin
            if (NotAnInstr) begin
               take  = 1'b1;
               esr_w = ESR_INVALID;
            end else if (InconBranch) begin
               take  = 1'b1;
               esr_w = ESR_INCON_BR;
            end else if (ERet) begin
               take  = 1'b1;
               esr_w = ESR_BAD_ERET;
            end else if (irq_req && !ack_q) begin
               take  = 1'b1;
               esr_w = ESR_IRQ;
               ack_d = 1'b1;
            end
            if (take) begin
               exc_c   = 1'b1;
               kill_c  = 1'b1;
               state_d = HANDLER;
            end
         end
         HANDLER: begin
            if (NotAnInstr || InconBranch) begin
               kill_c  = 1'b1;
               state_d = HALTED;
            end else if (ERet) begin
               ret_c   = 1'b1;
               kill_c  = 1'b1;
               state_d = RUN;
            end
         end
         HALTED: begin
            kill_c = 1'b1;
         end
         default: state_d = RUN;
      endcase
   end

   // State and acknowledge registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
      end
   end

   exc_sysregs #(.N(N)) u_sysregs (
      .clk        (clk),
      .reset      (reset),
      .we         (take),
      .elr_wdata  (PC),
      .esr_wdata  (esr_w),
      .sel        (SysRegSel),
      .in_handler (InHandler),
      .elr        (ELR),
      .esr        (ESR),
      .rdata      (SysRegData)
   );

   assign InHandler = (state_q == HANDLER);
   assign Exc       = exc_c  & ~reset;
   assign Kill      = kill_c & ~reset;
   assign RetTake   = ret_c  & ~reset;
   assign Halt      = (state_q == HALTED) & ~reset;
   assign ExtIAck   = ack_q;
   assign EVAddr    = EVEC;
   assign RetAddr   = ELR;

endmodule

// File: tb/tb_exc_unit.sv
// Directed scoreboard bench for exc_unit. Expected values per cycle are
// queued by the driver and checked by a separate negedge monitor.
module tb_exc_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] PC;
   logic        NotAnInstr, InconBranch, ERet, ExtIRQ;
   logic [1:0]  SysRegSel;
   logic        Exc, Kill, RetTake, InHandler, Halt, ExtIAck;
   logic [63:0] EVAddr, RetAddr, ELR, SysRegData;
   logic [3:0]  ESR;

   typedef struct {
      string       name;
      logic        exc, kill, rt, halt, inh, ack;
      logic [63:0] elr;
      logic [3:0]  esr;
      logic [63:0] srd;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   exc_unit #(.N(64), .EVEC(64'h0000_0000_0000_00D8)) dut (
      .clk(clk), .reset(reset), .PC(PC), .NotAnInstr(NotAnInstr),
      .InconBranch(InconBranch), .ERet(ERet), .ExtIRQ(ExtIRQ),
      .SysRegSel(SysRegSel), .Exc(Exc), .Kill(Kill), .EVAddr(EVAddr),
      .RetAddr(RetAddr), .RetTake(RetTake), .ELR(ELR), .ESR(ESR),
      .InHandler(InHandler), .Halt(Halt), .ExtIAck(ExtIAck),
      .SysRegData(SysRegData)
   );

   task automatic chk(input string nm, input string fld, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s.%s got %0h expected %0h", nm, fld, got, want);
      end
   endtask

   // Monitor: pops one expectation per cycle and compares outputs
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk(e.name, "Exc",        {63'b0, Exc},       {63'b0, e.exc});
         chk(e.name, "Kill",       {63'b0, Kill},      {63'b0, e.kill});
         chk(e.name, "RetTake",    {63'b0, RetTake},   {63'b0, e.rt});
         chk(e.name, "Halt",       {63'b0, Halt},      {63'b0, e.halt});
         chk(e.name, "InHandler",  {63'b0, InHandler}, {63'b0, e.inh});
         chk(e.name, "ExtIAck",    {63'b0, ExtIAck},   {63'b0, e.ack});
         chk(e.name, "ELR",        ELR,                e.elr);
         chk(e.name, "RetAddr",    RetAddr,            e.elr);
         chk(e.name, "ESR",        {60'b0, ESR},       {60'b0, e.esr});
         chk(e.name, "SysRegData", SysRegData,         e.srd);
         chk(e.name, "EVAddr",     EVAddr,             64'hD8);
      end
   end

   // Drive one cycle of inputs and queue the expected response
   task automatic cyc(input string nm, input logic rst, input logic [63:0] pc,
                      input logic nai, input logic ib, input logic er, input logic irq,
                      input logic [1:0] sel,
                      input logic e_exc, input logic e_kill, input logic e_rt, input logic e_halt,
                      input logic e_inh, input logic e_ack, input logic [63:0] e_elr, input logic [3:0] e_esr);
      exp_t e;
      reset = rst; PC = pc; NotAnInstr = nai; InconBranch = ib; ERet = er;
      ExtIRQ = irq; SysRegSel = sel;
      e.name = nm; e.exc = e_exc; e.kill = e_kill; e.rt = e_rt; e.halt = e_halt;
      e.inh = e_inh; e.ack = e_ack; e.elr = e_elr; e.esr = e_esr;
      case (sel)
         2'b00:   e.srd = e_elr;
         2'b01:   e.srd = {60'b0, e_esr};
         2'b10:   e.srd = {63'b0, e_inh};
         default: e.srd = '0;
      endcase
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; PC = '0; NotAnInstr = 0; InconBranch = 0; ERet = 0;
      ExtIRQ = 0; SysRegSel = 2'd0;
      @(posedge clk); #1;
      //  name            rst pc          nai ib er irq sel  exc kill rt halt inh ack elr          esr
      cyc("reset_hold",    1, 64'h40,      1, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 64'h0,  4'h0);
      cyc("nai_take",      0, 64'h40,      1, 0, 0, 0, 2'd0, 1, 1, 0, 0, 0, 0, 64'h0,  4'h0);
      cyc("in_handler",    0, 64'hD8,      0, 0, 0, 0, 2'd1, 0, 0, 0, 0, 1, 0, 64'h40, 4'h1);
      cyc("eret_take",     0, 64'hDC,      0, 0, 1, 0, 2'd2, 0, 1, 1, 0, 1, 0, 64'h40, 4'h1);
      cyc("back_run",      0, 64'h40,      0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 64'h40, 4'h1);
      cyc("bad_eret",      0, 64'h44,      0, 0, 1, 0, 2'd0, 1, 1, 0, 0, 0, 0, 64'h40, 4'h1);
      cyc("bad_eret_regs", 0, 64'hD8,      0, 0, 0, 0, 2'd1, 0, 0, 0, 0, 1, 0, 64'h44, 4'h4);
      cyc("double_fault",  0, 64'hDC,      0, 1, 0, 0, 2'd1, 0, 1, 0, 0, 1, 0, 64'h44, 4'h4);
      cyc("halted",        0, 64'hE0,      1, 0, 1, 1, 2'd3, 0, 1, 0, 1, 0, 0, 64'h44, 4'h4);
      cyc("halted_hold",   0, 64'hE4,      0, 1, 0, 0, 2'd0, 0, 1, 0, 1, 0, 0, 64'h44, 4'h4);
      cyc("reset_halted",  1, 64'hE8,      1, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 64'h44, 4'h4);
      cyc("after_reset",   0, 64'h0,       0, 0, 0, 0, 2'd1, 0, 0, 0, 0, 0, 0, 64'h0,  4'h0);
`ifdef EXC_IRQ_EN
      cyc("irq_take",      0, 64'h80,      0, 0, 0, 1, 2'd0, 1, 1, 0, 0, 0, 0, 64'h0,  4'h0);
      cyc("irq_regs",      0, 64'hD8,      0, 0, 0, 1, 2'd1, 0, 0, 0, 0, 1, 1, 64'h80, 4'h2);
      cyc("irq_eret",      0, 64'hDC,      0, 0, 1, 1, 2'd0, 0, 1, 1, 0, 1, 1, 64'h80, 4'h2);
      cyc("irq_hold1",     0, 64'h80,      0, 0, 0, 1, 2'd0, 0, 0, 0, 0, 0, 1, 64'h80, 4'h2);
      cyc("irq_hold2",     0, 64'h84,      0, 0, 0, 1, 2'd0, 0, 0, 0, 0, 0, 1, 64'h80, 4'h2);
      cyc("irq_drop",      0, 64'h88,      0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 1, 64'h80, 4'h2);
      cyc("ack_clear",     0, 64'h8C,      0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 64'h80, 4'h2);
      cyc("sync_vs_irq",   0, 64'h100,     1, 0, 0, 1, 2'd0, 1, 1, 0, 0, 0, 0, 64'h80, 4'h2);
      cyc("irq_masked",    0, 64'hD8,      0, 0, 0, 1, 2'd1, 0, 0, 0, 0, 1, 0, 64'h100,4'h1);
      cyc("eret_pending",  0, 64'hDC,      0, 0, 1, 1, 2'd0, 0, 1, 1, 0, 1, 0, 64'h100,4'h1);
      cyc("irq_on_return", 0, 64'h100,     0, 0, 0, 1, 2'd0, 1, 1, 0, 0, 0, 0, 64'h100,4'h1);
      cyc("irq2_regs",     0, 64'hD8,      0, 0, 0, 0, 2'd1, 0, 0, 0, 0, 1, 1, 64'h100,4'h2);
      cyc("irq2_ack_clr",  0, 64'hDC,      0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 1, 0, 64'h100,4'h2);
`else
      for (int i = 0; i < 10; i++) begin
         cyc("irq_ignored", 0, 64'h80 + 64'(4 * i), 0, 0, 0, 1, 2'd0, 0, 0, 0, 0, 0, 0, 64'h0, 4'h0);
      end
`endif
      @(negedge clk); #1;
      chk("drain", "queue", 64'(q.size()), 64'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/exc_unit.md
# exc_unit

Exception responder for the LEGv8 single-cycle core. It consumes the decoder's exception flags (NotAnInstr, InconBranch, ERet) and an external interrupt line. It redirects the PC to the exception vector and suppresses the faulting instruction's side effects. It also holds the ELR/ESR system registers read by MRS and runs the ERET return and the interrupt acknowledge handshake.

## Interface
- N, 64, datapath/address width
- EVEC, 64'h0000_0000_0000_00D8, exception vector address
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- PC  in  N  address of the instruction currently decoded
- NotAnInstr  in  1  decoder: invalid opcode
- InconBranch  in  1  decoder: inconsistent branch
- ERet  in  1  decoder: ERET
- ExtIRQ  in  1  external interrupt request, level
- SysRegSel  in  2  MRS select: 00 ELR, 01 ESR (zero-extended), 10 {63'b0, InHandler}, 11 zero
- Exc  out  1  take exception this cycle (PC mux selects EVAddr)
- Kill  out  1  suppress RegWrite/MemWrite/MemRead of current instruction
- EVAddr  out  N  constant EVEC
- RetAddr  out  N  ERET target (= ELR)
- RetTake  out  1  ERET accepted this cycle (PC mux selects RetAddr)
- ELR  out  N  exception link register
- ESR  out  4  exception syndrome
- InHandler  out  1  handler state active
- Halt  out  1  double fault, core must stop fetching
- ExtIAck  out  1  interrupt acknowledge
- SysRegData  out  N  MRS read data, combinational

## Operation
- States: RUN, HANDLER, HALTED. Reset → RUN.
- Cause priority, highest first: NotAnInstr (ESR 4'b0001), InconBranch (4'b0011), illegal ERET (ERet while RUN, 4'b0100), ExtIRQ (4'b0010).
- RUN, sync cause present: Exc=1, Kill=1 same cycle. At the edge: ELR←PC, ESR←code, state→HANDLER.
- RUN, no sync cause, ExtIRQ=1, ExtIAck=0: Exc=1, Kill=1 (instruction at PC not executed). At the edge: ELR←PC, ESR←0010, ExtIAck←1, state→HANDLER.
- HANDLER, ERet=1 with no higher cause: RetTake=1, Kill=1. At the edge: state→RUN. ELR/ESR unchanged.
- HANDLER, NotAnInstr or InconBranch: double fault. Kill=1, Exc=0. At the edge: state→HALTED. ELR/ESR keep the original cause.
- HANDLER: ExtIRQ is masked and stays pending until return to RUN.
- HALTED: Halt=1, Kill=1 every cycle, all inputs ignored; only reset exits.
- ExtIAck is a 4-phase handshake:
  - set on the edge the IRQ is taken;
  - cleared on the first edge at which ExtIRQ is sampled 0;
  - no new IRQ is taken while ExtIAck=1.
- Exc, RetTake, Kill and Halt are forced 0 while reset=1.

## Timing
- Reset values: state RUN, ELR 0, ESR 0, ExtIAck 0, InHandler 0, Halt 0.
- Exc/Kill/RetTake are combinational from inputs and state: zero-latency redirect, so the next-cycle PC = EVEC or ELR.
- ELR/ESR/InHandler/Halt/ExtIAck update one edge after the decision.
- SysRegData reflects the register values before the current edge (MRS in the same cycle as an exception is killed anyway).
- Reset mid-handler: returns to RUN on the next edge and clears ExtIAck regardless of ExtIRQ.
- Simultaneous sync cause and ExtIRQ in RUN: the sync cause wins. The IRQ stays pending (not acked) and becomes masked once HANDLER is entered.

## Configuration
- EXC_IRQ_EN defined: external interrupt path and ExtIAck handshake present as specified.
- EXC_IRQ_EN undefined: ExtIRQ ignored, ExtIAck tied 0, ESR code 0010 never produced; all other behaviour identical.

## Structure
- Package exc_pkg holds:
  - ESR code constants: ESR_INVALID, ESR_IRQ, ESR_INCON_BR, ESR_BAD_ERET;
  - the state enum exc_state_t {RUN, HANDLER, HALTED};
  - the default EVEC.
- Sub-module exc_sysregs: ELR/ESR storage with a synchronous write port and the combinational SysRegSel read mux.
- exc_unit keeps the FSM, priority encoder and IRQ handshake.

## Test plan
- RUN, PC=0x40, NotAnInstr=1 → Exc=1, Kill=1 same cycle; next cycle ELR=0x40, ESR=0001, InHandler=1.
- HANDLER, ERet=1 → RetTake=1, RetAddr=0x40; next cycle InHandler=0; a subsequent ERet in RUN → Exc=1, ESR=0100.
- RUN, PC=0x80, ExtIRQ=1 → Exc=1; next cycle ESR=0010, ExtIAck=1. Hold ExtIRQ for 3 cycles → ExtIAck stays 1, no re-entry. Drop ExtIRQ → ExtIAck=0 the next cycle.
- RUN, NotAnInstr=1 and ExtIRQ=1 together → ESR=0001, ExtIAck=0. After ERet with ExtIRQ still 1 → IRQ taken with ELR = return-path PC.
- HANDLER, InconBranch=1 → next cycle Halt=1, ESR unchanged. Further inputs give no change. reset → all outputs at reset values.
- EXC_IRQ_EN undefined: ExtIRQ=1 for 10 cycles in RUN → Exc=0, ExtIAck=0 throughout.
